// File: rtl/fetch_queue.sv
`default_nettype none
// ============================================================================
// fetch_queue : sequential instruction fetch into a small FIFO feeding decode.
// Optional macro FETCH_STATS_EN adds fetched/flushed statistics counters.
// Revision 1.0
// ============================================================================
module fetch_queue #(
  parameter int DEPTH   = 4,
  parameter int INSTR_W = 9,
  parameter int ADDR_W  = 32
) (
  input  logic               clk,
  input  logic               reset,
  output logic               imem_req,
  output logic [ADDR_W-1:0]  imem_addr,
  input  logic [INSTR_W-1:0] imem_rdata,
  input  logic               redirect_en,
  input  logic [ADDR_W-1:0]  redirect_pc,
  output logic               instr_valid,
  output logic [INSTR_W-1:0] instr,
  output logic [ADDR_W-1:0]  instr_pc,
  input  logic               instr_ready
`ifdef FETCH_STATS_EN
  ,
  output logic [15:0]        stat_fetched,
  output logic [15:0]        stat_flushed
`endif
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] C_DEPTH = CW'(DEPTH);

  logic [PW-1:0]      r_head;
  logic [PW-1:0]      r_tail;
  logic [CW-1:0]      r_count;
  logic               r_inflight;
  logic [ADDR_W-1:0]  r_fetch_pc;
  logic [ADDR_W-1:0]  r_inflight_pc;
  logic [INSTR_W-1:0] r_instr_mem [DEPTH];
  logic [ADDR_W-1:0]  r_pc_mem    [DEPTH];

  logic [CW-1:0]      w_occupancy;
  logic               w_issue;
  logic               w_push;
  logic               w_pop;

  // Counting the in-flight word reserves its slot, so a response never overflows.
  assign w_occupancy = r_count + CW'(r_inflight);
  assign w_issue     = !reset && !redirect_en && (w_occupancy < C_DEPTH);
  assign w_push      = r_inflight && !redirect_en;
  assign w_pop       = instr_valid && instr_ready && !redirect_en;

  assign imem_req    = w_issue;
  assign imem_addr   = r_fetch_pc;
  assign instr_valid = (r_count != '0);
  assign instr       = r_instr_mem[r_head];
  assign instr_pc    = r_pc_mem[r_head];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_fetch_pc    <= '0;
      r_inflight    <= 1'b0;
      r_inflight_pc <= '0;
    end else if (redirect_en) begin
      r_fetch_pc <= redirect_pc;
      r_inflight <= 1'b0;
    end else begin
      r_inflight <= w_issue;
      if (w_issue) begin
        r_fetch_pc    <= r_fetch_pc + ADDR_W'(1);
        r_inflight_pc <= r_fetch_pc;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else if (redirect_en) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) r_tail <= r_tail + PW'(1);
      if (w_pop)  r_head <= r_head + PW'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Storage carries no reset; entries are only observed while counted valid.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_instr_mem[r_tail] <= imem_rdata;
      r_pc_mem[r_tail]    <= r_inflight_pc;
    end
  end

`ifdef FETCH_STATS_EN
  logic [15:0] r_stat_fetched;
  logic [15:0] r_stat_flushed;
  logic [16:0] w_flush_sum;

  assign w_flush_sum  = {1'b0, r_stat_flushed} + 17'(r_count) + 17'(r_inflight);
  assign stat_fetched = r_stat_fetched;
  assign stat_flushed = r_stat_flushed;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_stat_fetched <= '0;
      r_stat_flushed <= '0;
    end else begin
      if (w_push && (r_stat_fetched != 16'hFFFF))
        r_stat_fetched <= r_stat_fetched + 16'd1;
      if (redirect_en)
        r_stat_flushed <= w_flush_sum[16] ? 16'hFFFF : w_flush_sum[15:0];
    end
  end
`endif

endmodule
`default_nettype wire

// File: tb/tb_fetch_queue.sv
`default_nettype none
// Scoreboard bench for fetch_queue: directed phases push expected PCs,
// an independent monitor checks every accepted instruction.
module tb_fetch_queue;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        redirect_en = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic        instr_ready = 1'b0;
  logic [8:0]  imem_rdata = '0;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        instr_valid;
  logic [8:0]  instr;
  logic [31:0] instr_pc;
`ifdef FETCH_STATS_EN
  logic [15:0] stat_fetched;
  logic [15:0] stat_flushed;
`endif

  int n_chk = 0;
  int n_err = 0;
  logic [31:0] exp_q[$];
  logic [31:0] mon_e;

  fetch_queue #(.DEPTH(4), .INSTR_W(9), .ADDR_W(32)) dut (
    .clk(clk),
    .reset(reset),
    .imem_req(imem_req),
    .imem_addr(imem_addr),
    .imem_rdata(imem_rdata),
    .redirect_en(redirect_en),
    .redirect_pc(redirect_pc),
    .instr_valid(instr_valid),
    .instr(instr),
    .instr_pc(instr_pc),
    .instr_ready(instr_ready)
`ifdef FETCH_STATS_EN
    ,
    .stat_fetched(stat_fetched),
    .stat_flushed(stat_flushed)
`endif
  );

  always #5 clk = ~clk;

  // Instruction memory: word returned one cycle after the request is its address.
  always @(posedge clk) begin
    if (imem_req) imem_rdata <= imem_addr[8:0];
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    n_chk++;
    if (act !== expv) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, expv);
    end
  endtask

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic drain(input int max_cycles);
    int n = 0;
    while (exp_q.size() != 0 && n < max_cycles) begin
      step();
      n++;
    end
    n_chk++;
    if (exp_q.size() != 0) begin
      n_err++;
      $display("FAIL drain_timeout: got %0d outstanding expected 0", exp_q.size());
      exp_q.delete();
    end
  endtask

  // Monitor samples mid-way between the negedge stimulus update and the next posedge.
  initial begin
    forever begin
      @(negedge clk);
      #3;
      if (!reset && instr_valid && instr_ready && !redirect_en) begin
        if (exp_q.size() == 0) begin
          n_chk++;
          n_err++;
          $display("FAIL unexpected_instr: got pc %0h expected none", instr_pc);
        end else begin
          mon_e = exp_q.pop_front();
          chk("instr_pc", instr_pc, mon_e);
          chk("instr", {23'b0, instr}, {23'b0, mon_e[8:0]});
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    step();
    chk("reset_req", {31'b0, imem_req}, 32'd0);
    chk("reset_valid", {31'b0, instr_valid}, 32'd0);
    chk("reset_addr", imem_addr, 32'd0);

    // Streaming with ready held high
    reset = 1'b0;
    instr_ready = 1'b1;
    for (int i = 0; i < 8; i++) exp_q.push_back(32'(i));
    #1;
    chk("t1_req0", {31'b0, imem_req}, 32'd1);
    chk("t1_addr0", imem_addr, 32'd0);
    chk("t1_valid0", {31'b0, instr_valid}, 32'd0);
    step();
    chk("t1_addr1", imem_addr, 32'd1);
    chk("t1_valid1", {31'b0, instr_valid}, 32'd0);
    step();
    chk("t1_valid2", {31'b0, instr_valid}, 32'd1);
    chk("t1_addr2", imem_addr, 32'd2);
    drain(20);

    // Asynchronous reset between edges
    reset = 1'b1;
    #1;
    chk("ar_valid", {31'b0, instr_valid}, 32'd0);
    chk("ar_req", {31'b0, imem_req}, 32'd0);
    step();

    // Fill with ready low
    reset = 1'b0;
    instr_ready = 1'b0;
    #1;
    for (int i = 0; i < 4; i++) begin
      chk("t2_req", {31'b0, imem_req}, 32'd1);
      chk("t2_addr", imem_addr, 32'(i));
      step();
    end
    chk("t2_full_req", {31'b0, imem_req}, 32'd0);
    step();
    chk("t2_full_req2", {31'b0, imem_req}, 32'd0);
    chk("t2_full_valid", {31'b0, instr_valid}, 32'd1);
    chk("t2_full_pc", instr_pc, 32'd0);
    for (int i = 0; i < 6; i++) exp_q.push_back(32'(i));
    instr_ready = 1'b1;
    #1;
    chk("t2_pop_req", {31'b0, imem_req}, 32'd0);
    step();
    chk("t2_resume_req", {31'b0, imem_req}, 32'd1);
    chk("t2_resume_addr", imem_addr, 32'd4);
    drain(20);
    instr_ready = 1'b0;

    // Redirect with 5..7 queued and 8 in flight
    reset = 1'b1;
    step();
    reset = 1'b0;
    redirect_en = 1'b1;
    redirect_pc = 32'd5;
    #1;
    chk("t3_redir_req", {31'b0, imem_req}, 32'd0);
    step();
    redirect_en = 1'b0;
    #1;
    chk("t3_req5", {31'b0, imem_req}, 32'd1);
    chk("t3_addr5", imem_addr, 32'd5);
    step();
    chk("t3_addr6", imem_addr, 32'd6);
    step();
    chk("t3_addr7", imem_addr, 32'd7);
    step();
    chk("t3_addr8", imem_addr, 32'd8);
    chk("t3_req8", {31'b0, imem_req}, 32'd1);
    step();
    redirect_en = 1'b1;
    redirect_pc = 32'h40;
    #1;
    chk("t3_hold_req", {31'b0, imem_req}, 32'd0);
    chk("t3_hold_valid", {31'b0, instr_valid}, 32'd1);
    chk("t3_hold_pc", instr_pc, 32'd5);
    exp_q.push_back(32'h40);
    exp_q.push_back(32'h41);
    exp_q.push_back(32'h42);
    step();
    redirect_en = 1'b0;
    instr_ready = 1'b1;
    #1;
    chk("t3_flush_valid", {31'b0, instr_valid}, 32'd0);
    chk("t3_restart_req", {31'b0, imem_req}, 32'd1);
    chk("t3_restart_addr", imem_addr, 32'h40);
`ifdef FETCH_STATS_EN
    chk("t3_stat_fetched", {16'b0, stat_fetched}, 32'd3);
    chk("t3_stat_flushed", {16'b0, stat_flushed}, 32'd4);
`endif
    drain(20);

    // Redirect colliding with a pop and a push (head 0x43, 0x44 in flight)
    redirect_en = 1'b1;
    redirect_pc = 32'h80;
    #1;
    chk("t4_valid", {31'b0, instr_valid}, 32'd1);
    chk("t4_head", instr_pc, 32'h43);
    chk("t4_req", {31'b0, imem_req}, 32'd0);
    for (int i = 0; i < 6; i++) exp_q.push_back(32'h80 + 32'(i));
    step();
    redirect_en = 1'b0;
    #1;
    chk("t4_flush_valid", {31'b0, instr_valid}, 32'd0);
    chk("t4_restart_addr", imem_addr, 32'h80);
`ifdef FETCH_STATS_EN
    chk("t4_stat_fetched", {16'b0, stat_fetched}, 32'd7);
    chk("t4_stat_flushed", {16'b0, stat_flushed}, 32'd6);
`endif
    drain(20);

    // Refill to full after the collision to exercise pointer wrap
    instr_ready = 1'b0;
    for (int i = 0; i < 6; i++) exp_q.push_back(32'h86 + 32'(i));
    for (int i = 0; i < 4; i++) step();
    chk("t4_full_req", {31'b0, imem_req}, 32'd0);
    chk("t4_full_pc", instr_pc, 32'h86);
    instr_ready = 1'b1;
    drain(20);
    instr_ready = 1'b0;

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/fetch_queue.md
Name: fetch_queue

Overview:
- Consumer side of the program-counter interface.
- Generates sequential instruction-memory read addresses and captures the returned instruction words into a small FIFO.
- Presents those instructions to decode with a valid/ready handshake.
- Accepts a redirect (taken branch) that flushes all buffered and in-flight fetches and restarts fetch at a new address.
- Sits between instruction memory and the decoder.

Parameters:
- DEPTH, 4, queue entries; power of two, >= 2.
- INSTR_W, 9, instruction word width.
- ADDR_W, 32, fetch address width.

Ports:
- clk  input  1  clock, rising edge.
- reset  input  1  asynchronous, active-high reset.
- imem_req  output  1  read request to instruction memory this cycle.
- imem_addr  output  ADDR_W  read address; meaningful only when imem_req=1.
- imem_rdata  input  INSTR_W  read data; valid exactly one cycle after the request.
- redirect_en  input  1  flush and restart fetch.
- redirect_pc  input  ADDR_W  restart address, sampled when redirect_en=1.
- instr_valid  output  1  head entry present.
- instr  output  INSTR_W  head instruction.
- instr_pc  output  ADDR_W  address of head instruction.
- instr_ready  input  1  decoder accepts head this cycle.

Behaviour:
- Reset: fetch_pc=0, queue empty (count=0, pointers 0), in-flight flag clear, imem_req=0 while reset is held, instr_valid=0. instr and instr_pc are don't-care when instr_valid=0 and are driven from entry 0 after reset.
- Reset asserted mid-operation clears everything immediately (asynchronous); buffered and in-flight data are lost.
- Issue rule: imem_req = !redirect_en && (count + inflight) < DEPTH. This guarantees that every returned word has a free slot.
- imem_addr = fetch_pc.
- On an issued request: fetch_pc <= fetch_pc+1 (wraps modulo 2^ADDR_W), inflight <= 1, inflight_pc <= fetch_pc. Otherwise inflight <= 0.
- Response: when inflight=1 and no redirect this cycle, write {imem_rdata, inflight_pc} at the tail; tail advances modulo DEPTH.
- Pop: when instr_valid && instr_ready, head advances modulo DEPTH.
- count update: +1 on push, -1 on pop, unchanged when both occur in the same cycle.
- Outputs are combinational from the head entry: instr_valid = (count != 0).
- Redirect priority, in the redirect_en=1 cycle:
  - Queue cleared (head=tail=count=0).
  - Response arriving this cycle is discarded.
  - Any pop is ignored.
  - inflight <= 0.
  - fetch_pc <= redirect_pc.
  - No request is issued.
  - Next cycle: imem_req=1 with imem_addr=redirect_pc.
- Back-to-back redirects: only the last one takes effect; the request goes out the cycle after redirect_en drops.
- Latency:
  - Request at cycle N, data enqueued at edge end of N+1, instr_valid at N+2.
  - Steady state with instr_ready=1: one instruction per cycle after a 2-cycle fill.
- Full: when count+inflight = DEPTH, no request. A pop in the same cycle does not enable a request that cycle; the decision uses registered count.
- Empty with ready=1: instr_valid=0 and no pop occurs.

Optional Feature:
- Macro: FETCH_STATS_EN.
- Defined:
  - Adds output stat_fetched[15:0], counting instructions enqueued.
  - Adds output stat_flushed[15:0], counting valid entries plus in-flight words discarded by redirects (adds count + inflight on each redirect).
  - Both counters saturate at 16'hFFFF and reset to 0.
- Undefined: these ports and their logic do not exist; the core behaviour is identical either way.

Test Plan:
- Reset release, memory returns rdata = addr[8:0], instr_ready=1:
  - Requests at addresses 0,1,2,… on consecutive cycles.
  - instr_valid rises 2 cycles after the first request.
  - Outputs instr_pc = 0,1,2,… with instr equal to each address, one per cycle.
- instr_ready=0 held:
  - Exactly 4 requests (addr 0–3), then imem_req=0.
  - count=4, head instr_pc=0.
  - After ready rises, drains 0,1,2,3 in order and fetch resumes at addr 4.
- Redirect with the queue holding pc 5–7 and addr 8 in flight, redirect_pc=0x40:
  - instr_valid=0 next cycle; word for 8 is never presented.
  - imem_addr=0x40 the cycle after the redirect; first presented instr_pc=0x40.
- Redirect in the same cycle as a pop and a push:
  - Queue ends empty, no element from before the redirect appears.
  - Pointers are consistent on refill.
- Async reset asserted mid-stream between clock edges: instr_valid and imem_req drop immediately; after release, fetch restarts at address 0.
- FETCH_STATS_EN: run 10 fetches, then redirect with 3 queued + 1 in flight → stat_fetched=10, stat_flushed=4.
